// File: rtl/tx_byte_striping.sv
// Byte striping stage after TX framing: symbol k of the framed word goes to lane k, inactive
// lanes are zeroed, and a 16-symbol 128b/130b block counter drives sync headers for Gen3+ rates.
module tx_byte_striping #(
  parameter int unsigned SYMBOL_WIDTH     = 8,
  parameter int unsigned SYMBOL_NUM_WIDTH = 4,
  parameter int unsigned SYMBOL_PTR_WIDTH = 5,
  parameter int unsigned MAX_LANES        = 2**SYMBOL_PTR_WIDTH,
  parameter int unsigned BLOCK_SYMBOLS    = 16
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              i_EN,
  input  logic [1:0]                        i_GEN_Lanes,
  input  logic [SYMBOL_WIDTH*MAX_LANES-1:0] i_Framed_Data,
  input  logic                              i_Sync_Sel,
  input  logic                              i_Idle_Indicator,
  output logic [SYMBOL_NUM_WIDTH-1:0]       o_Symbol_Num,
  output logic [SYMBOL_WIDTH*MAX_LANES-1:0] o_Lane_Data,
  output logic [MAX_LANES-1:0]              o_Lane_Valid,
  output logic [1:0]                        o_Sync_Hdr,
  output logic                              o_Sync_Valid,
  output logic                              o_Idle,
  output logic                              o_Block_Abort
);

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] HDR_OS   = 2'b01;
  localparam logic [1:0] HDR_DATA = 2'b10;

  state_e                            state_q, state_d;
  logic [SYMBOL_NUM_WIDTH-1:0]       cnt_q, cnt_d;
  logic [1:0]                        mode_q, mode_d;
  logic [SYMBOL_WIDTH*MAX_LANES-1:0] data_q, data_d;
  logic [MAX_LANES-1:0]              valid_q, valid_d;
  logic [1:0]                        hdr_q, hdr_d;
  logic                              sync_vld_q, sync_vld_d;
  logic                              idle_q, idle_d;
  logic                              abort_q, abort_d;

  logic                              gen3;
  logic                              mode_chg;
  logic                              cnt_busy;
  logic [MAX_LANES-1:0]              lane_mask;

  // Mask and rate follow the incoming mode so a mode-change cycle already uses the new lanes.
  assign gen3      = i_GEN_Lanes[0];
  assign mode_chg  = (i_GEN_Lanes != mode_q);
  assign cnt_busy  = (cnt_q != '0);
  assign lane_mask = i_GEN_Lanes[1] ? '1 : MAX_LANES'(1);

  always_comb begin
    state_d    = (gen3 && i_EN) ? ST_RUN : ST_HALT;
    cnt_d      = cnt_q;
    mode_d     = i_GEN_Lanes;
    hdr_d      = hdr_q;
    sync_vld_d = 1'b0;
    abort_d    = 1'b0;
    idle_d     = i_Idle_Indicator;
    valid_d    = lane_mask;
    data_d     = '0;

    if (mode_chg) begin
      cnt_d   = '0;
      abort_d = cnt_busy;
    end else if (gen3) begin
      if (i_EN) begin
        if (cnt_q == SYMBOL_NUM_WIDTH'(BLOCK_SYMBOLS - 1)) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + SYMBOL_NUM_WIDTH'(1);
        end
        if (!cnt_busy) begin
          hdr_d      = i_Sync_Sel ? HDR_OS : HDR_DATA;
          sync_vld_d = 1'b1;
        end
      end else begin
        cnt_d   = '0;
        abort_d = (state_q == ST_RUN) && cnt_busy;
      end
    end else begin
      cnt_d = '0;
    end

    if (!gen3) begin
      hdr_d = '0;
    end

    if (gen3 && !i_EN) begin
      valid_d = '0;
    end

    for (int unsigned k = 0; k < MAX_LANES; k++) begin
      if (valid_d[k]) begin
        data_d[k*SYMBOL_WIDTH +: SYMBOL_WIDTH] = i_Framed_Data[k*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_HALT;
      cnt_q      <= '0;
      mode_q     <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      hdr_q      <= '0;
      sync_vld_q <= 1'b0;
      idle_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      hdr_q      <= hdr_d;
      sync_vld_q <= sync_vld_d;
      idle_q     <= idle_d;
      abort_q    <= abort_d;
    end
  end

  assign o_Symbol_Num  = cnt_q;
  assign o_Lane_Data   = data_q;
  assign o_Lane_Valid  = valid_q;
  assign o_Sync_Hdr    = hdr_q;
  assign o_Sync_Valid  = sync_vld_q;
  assign o_Idle        = idle_q;
  assign o_Block_Abort = abort_q;

endmodule
